clint: RTL and testbench

CLINT -- requirements
Module: clint

---
 rtl/clint_pkg.sv | 21 ++
 rtl/clint_if.sv | 31 +++
 rtl/clint.sv | 124 ++++++++++++
 tb/tb_clint.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/clint_pkg.sv
// Shared CLINT constants: CSR addresses, trap cause codes and system instruction encodings.
package clint_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam logic [63:0] CAUSE_ECALL  = 64'd11;
    localparam logic [63:0] CAUSE_EBREAK = 64'd3;

    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INST_MRET   = 32'h3020_0073;

    // The CSR write port is 64 bits wide; only the 12-bit CSR number is meaningful.
    function automatic logic [63:0] csr_addr(input logic [11:0] num);
        return {52'd0, num};
    endfunction

endpackage

// File: rtl/clint_if.sv
// Signal bundle between the core pipeline / CSR file and the CLINT trap sequencer.
interface clint_if;
    logic [31:0] inst;
    logic [63:0] inst_addr;
    logic        jump_flag;
    logic [63:0] jump_addr;
    logic        int_flag;
    logic [63:0] csr_mtvec;
    logic [63:0] csr_mepc;
    logic [63:0] csr_mstatus;
    logic        global_int_en;
    logic        we;
    logic [63:0] waddr;
    logic [63:0] raddr;
    logic [63:0] data;
    logic        hold_flag;
    logic        int_assert;
    logic [63:0] int_addr;

    modport slave (
        input  inst, inst_addr, jump_flag, jump_addr, int_flag,
        input  csr_mtvec, csr_mepc, csr_mstatus, global_int_en,
        output we, waddr, raddr, data, hold_flag, int_assert, int_addr
    );

    modport master (
        output inst, inst_addr, jump_flag, jump_addr, int_flag,
        output csr_mtvec, csr_mepc, csr_mstatus, global_int_en,
        input  we, waddr, raddr, data, hold_flag, int_assert, int_addr
    );
endinterface

// File: rtl/clint.sv
// CLINT trap sequencer: turns ECALL/EBREAK/timer interrupts into mepc/mstatus/mcause
// writes plus a PC redirect to mtvec, and MRET into an mstatus restore plus redirect to mepc.
//
// state            | meaning
// S_IDLE           | waiting for an event; hold asserted combinationally on detect
// S_W_MEPC         | write saved PC to mepc
// S_W_MSTATUS      | write mstatus with MPIE<=MIE, MIE<=0
// S_W_MCAUSE       | write latched cause to mcause
// S_ASSERT         | redirect strobe to mtvec
// S_W_MSTATUS_MRET | write mstatus with MIE<=MPIE, MPIE<=1
// S_ASSERT_MRET    | redirect strobe to mepc
module clint
    import clint_pkg::*;
#(
    parameter logic [63:0] TIMER_CAUSE = 64'h8000_0000_0000_0007
) (
    input  logic     clk,
    input  logic     rst,
    clint_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_W_MEPC,
        S_W_MSTATUS,
        S_W_MCAUSE,
        S_ASSERT,
        S_W_MSTATUS_MRET,
        S_ASSERT_MRET
    } state_t;

    state_t      state, state_next;
    logic [63:0] saved_pc, cause;
    logic        is_exc, is_irq, is_mret;
    logic [63:0] exc_cause;
    logic [63:0] ms;

    assign ms        = bus.csr_mstatus;
    assign is_exc    = (bus.inst == INST_ECALL) || (bus.inst == INST_EBREAK);
    assign exc_cause = (bus.inst == INST_EBREAK) ? CAUSE_EBREAK : CAUSE_ECALL;
    assign is_irq    = bus.int_flag && bus.global_int_en;
    assign is_mret   = (bus.inst == INST_MRET);
    assign bus.raddr = '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            saved_pc <= '0;
            cause    <= '0;
        end else begin
            state <= state_next;
            // Exceptions win over a simultaneous interrupt.
            if (state == S_IDLE && (is_exc || is_irq)) begin
                saved_pc <= is_exc ? bus.inst_addr
                                   : (bus.jump_flag ? bus.jump_addr : bus.inst_addr);
                cause    <= is_exc ? exc_cause : TIMER_CAUSE;
            end
        end
    end

    always_comb begin
        state_next     = state;
        bus.hold_flag  = 1'b0;
        bus.we         = 1'b0;
        bus.waddr      = '0;
        bus.data       = '0;
        bus.int_assert = 1'b0;
        bus.int_addr   = '0;
        case (state)
            S_IDLE: begin
                // Gate with rst so the detect stall cannot leak out while in reset.
                if (rst && (is_exc || is_irq)) begin
                    state_next    = S_W_MEPC;
                    bus.hold_flag = 1'b1;
                end else if (rst && is_mret) begin
                    state_next    = S_W_MSTATUS_MRET;
                    bus.hold_flag = 1'b1;
                end
            end
            S_W_MEPC: begin
                state_next    = S_W_MSTATUS;
                bus.hold_flag = 1'b1;
                bus.we        = 1'b1;
                bus.waddr     = csr_addr(CSR_MEPC);
                bus.data      = saved_pc;
            end
            S_W_MSTATUS: begin
                state_next    = S_W_MCAUSE;
                bus.hold_flag = 1'b1;
                bus.we        = 1'b1;
                bus.waddr     = csr_addr(CSR_MSTATUS);
                bus.data      = {ms[63:8], ms[3], ms[6:4], 1'b0, ms[2:0]};
            end
            S_W_MCAUSE: begin
                state_next    = S_ASSERT;
                bus.hold_flag = 1'b1;
                bus.we        = 1'b1;
                bus.waddr     = csr_addr(CSR_MCAUSE);
                bus.data      = cause;
            end
            S_ASSERT: begin
                state_next     = S_IDLE;
                bus.hold_flag  = 1'b1;
                bus.int_assert = 1'b1;
                bus.int_addr   = bus.csr_mtvec;
            end
            S_W_MSTATUS_MRET: begin
                state_next    = S_ASSERT_MRET;
                bus.hold_flag = 1'b1;
                bus.we        = 1'b1;
                bus.waddr     = csr_addr(CSR_MSTATUS);
                bus.data      = {ms[63:8], 1'b1, ms[6:4], ms[7], ms[2:0]};
            end
            S_ASSERT_MRET: begin
                state_next     = S_IDLE;
                bus.hold_flag  = 1'b1;
                bus.int_assert = 1'b1;
                bus.int_addr   = bus.csr_mepc;
            end
            default: state_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_clint.sv
// Self-checking bench for clint: directed scenarios then randomized traffic, every
// cycle compared against a script-based reference model of the trap/return sequences.
module tb_clint;
    import clint_pkg::*;

    localparam logic [63:0] TC  = 64'h8000_0000_0000_0007;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst = 1'b1;

    clint_if bus();

    clint #(.TIMER_CAUSE(TC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef enum int {K_MEPC, K_MST, K_CAUSE, K_ASSERT, K_MRET_MST, K_MRET_ASSERT} kind_t;
    typedef struct {
        logic [63:0] addr;
        logic [63:0] data;
    } wr_t;

    kind_t       plan[$];
    logic [63:0] m_pc, m_cause;
    wr_t         wlog[$];
    logic [63:0] alog[$];
    int          hold_cnt;
    int          n_assert = 0;
    int          n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One cycle: inputs already driven just after a negedge; check, log, advance model.
    task automatic tick();
        logic        e_hold, e_we, e_ia, exc, irq, mret;
        logic [63:0] e_wa, e_d, e_iaddr, ms;
        wr_t         w;
        #2;
        e_hold = 0; e_we = 0; e_ia = 0; e_wa = 0; e_d = 0; e_iaddr = 0;
        ms   = bus.csr_mstatus;
        exc  = (bus.inst == 32'h0000_0073) || (bus.inst == 32'h0010_0073);
        irq  = bus.int_flag && bus.global_int_en;
        mret = (bus.inst == 32'h3020_0073);
        if (rst) begin
            if (plan.size() == 0) begin
                e_hold = exc || irq || mret;
            end else begin
                e_hold = 1;
                case (plan[0])
                    K_MEPC:   begin e_we = 1; e_wa = 64'h341; e_d = m_pc; end
                    K_MST:    begin
                        e_we = 1; e_wa = 64'h300;
                        e_d  = (ms & ~64'h88) | ({63'd0, ms[3]} << 7);
                    end
                    K_CAUSE:  begin e_we = 1; e_wa = 64'h342; e_d = m_cause; end
                    K_ASSERT: begin e_ia = 1; e_iaddr = bus.csr_mtvec; end
                    K_MRET_MST: begin
                        e_we = 1; e_wa = 64'h300;
                        e_d  = (ms & ~64'h88) | ({63'd0, ms[7]} << 3) | 64'h80;
                    end
                    default:  begin e_ia = 1; e_iaddr = bus.csr_mepc; end
                endcase
            end
        end
        chk("hold_flag",  {63'd0, bus.hold_flag},  {63'd0, e_hold});
        chk("we",         {63'd0, bus.we},         {63'd0, e_we});
        chk("waddr",      bus.waddr,               e_wa);
        chk("data",       bus.data,                e_d);
        chk("int_assert", {63'd0, bus.int_assert}, {63'd0, e_ia});
        chk("int_addr",   bus.int_addr,            e_iaddr);
        chk("raddr",      bus.raddr,               64'd0);
        if (bus.we) begin
            w.addr = bus.waddr;
            w.data = bus.data;
            wlog.push_back(w);
        end
        if (bus.int_assert) alog.push_back(bus.int_addr);
        if (bus.hold_flag) hold_cnt++;
        if (!rst) begin
            plan.delete();
        end else if (plan.size() != 0) begin
            void'(plan.pop_front());
        end else if (exc) begin
            m_pc    = bus.inst_addr;
            m_cause = (bus.inst == 32'h0010_0073) ? 64'd3 : 64'd11;
            plan    = '{K_MEPC, K_MST, K_CAUSE, K_ASSERT};
        end else if (irq) begin
            m_pc    = bus.jump_flag ? bus.jump_addr : bus.inst_addr;
            m_cause = TC;
            plan    = '{K_MEPC, K_MST, K_CAUSE, K_ASSERT};
        end else if (mret) begin
            plan    = '{K_MRET_MST, K_MRET_ASSERT};
        end
        @(negedge clk);
    endtask

    task automatic clear_logs();
        wlog.delete();
        alog.delete();
        hold_cnt = 0;
    endtask

    initial begin
        bus.inst = NOP; bus.inst_addr = '0; bus.jump_flag = 0; bus.jump_addr = '0;
        bus.int_flag = 0; bus.csr_mtvec = '0; bus.csr_mepc = '0; bus.csr_mstatus = '0;
        bus.global_int_en = 0;
        #1 rst = 1'b0;
        @(negedge clk);

        // Events presented during reset must have no effect at all.
        bus.inst = INST_ECALL; bus.int_flag = 1; bus.global_int_en = 1;
        repeat (2) tick();

        // ECALL on the first edge after reset release.
        rst = 1'b1;
        bus.int_flag = 0;
        bus.inst_addr = 64'h8000_0010; bus.csr_mstatus = 64'h8; bus.csr_mtvec = 64'h8000_1000;
        clear_logs();
        tick();
        bus.inst = NOP;
        repeat (5) tick();
        chk("ecall_nwrites", wlog.size(), 3);
        if (wlog.size() == 3) begin
            chk("ecall_mepc_a", wlog[0].addr, 64'h341); chk("ecall_mepc_d", wlog[0].data, 64'h8000_0010);
            chk("ecall_mst_a",  wlog[1].addr, 64'h300); chk("ecall_mst_d",  wlog[1].data, 64'h80);
            chk("ecall_mc_a",   wlog[2].addr, 64'h342); chk("ecall_mc_d",   wlog[2].data, 64'd11);
        end
        chk("ecall_nstrobe", alog.size(), 1);
        if (alog.size() == 1) chk("ecall_target", alog[0], 64'h8000_1000);
        chk("ecall_hold", hold_cnt, 5);

        // Timer interrupt while EX redirects: saved PC is the jump target.
        clear_logs();
        bus.int_flag = 1; bus.global_int_en = 1; bus.jump_flag = 1; bus.jump_addr = 64'h8000_0200;
        tick();
        bus.int_flag = 0; bus.jump_flag = 0;
        repeat (5) tick();
        chk("irq_nwrites", wlog.size(), 3);
        if (wlog.size() == 3) begin
            chk("irq_mepc", wlog[0].data, 64'h8000_0200);
            chk("irq_cause", wlog[2].data, TC);
        end

        // MRET restores MIE from MPIE and redirects to mepc.
        clear_logs();
        bus.csr_mstatus = 64'h80; bus.csr_mepc = 64'h8000_0014; bus.inst = INST_MRET;
        tick();
        bus.inst = NOP;
        repeat (3) tick();
        chk("mret_nwrites", wlog.size(), 1);
        if (wlog.size() == 1) chk("mret_mst", wlog[0].data, 64'h88);
        chk("mret_nstrobe", alog.size(), 1);
        if (alog.size() == 1) chk("mret_target", alog[0], 64'h8000_0014);

        // ECALL beats a simultaneous interrupt; the held interrupt follows afterwards.
        clear_logs();
        bus.csr_mstatus = 64'h8; bus.inst = INST_ECALL; bus.int_flag = 1; bus.global_int_en = 1;
        tick();
        bus.inst = NOP;
        repeat (4) tick();
        tick();
        bus.int_flag = 0;
        repeat (5) tick();
        chk("prio_nwrites", wlog.size(), 6);
        if (wlog.size() == 6) begin
            chk("prio_first_cause", wlog[2].data, 64'd11);
            chk("prio_second_cause", wlog[5].data, TC);
        end

        // Interrupt masked by MIE=0: nothing happens.
        clear_logs();
        bus.int_flag = 1; bus.global_int_en = 0;
        repeat (4) tick();
        bus.int_flag = 0;
        chk("masked_writes", wlog.size(), 0);
        chk("masked_hold", hold_cnt, 0);

        // Reset in the middle of the trap sequence abandons it.
        clear_logs();
        bus.inst = INST_ECALL; bus.global_int_en = 1;
        tick();
        bus.inst = NOP;
        tick();
        rst = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_mid_writes", wlog.size(), 1);
        chk("rst_mid_strobe", alog.size(), 0);

        // Randomized traffic, including occasional asynchronous resets.
        repeat (500) begin
            case ($urandom_range(0, 9))
                0:       bus.inst = INST_ECALL;
                1:       bus.inst = INST_EBREAK;
                2:       bus.inst = INST_MRET;
                3, 4, 5: bus.inst = NOP;
                default: bus.inst = $urandom;
            endcase
            bus.inst_addr     = {$urandom, $urandom};
            bus.jump_flag     = $urandom_range(0, 1) == 1;
            bus.jump_addr     = {$urandom, $urandom};
            bus.int_flag      = $urandom_range(0, 3) == 0;
            bus.global_int_en = $urandom_range(0, 1) == 1;
            bus.csr_mtvec     = {$urandom, $urandom};
            bus.csr_mepc      = {$urandom, $urandom};
            bus.csr_mstatus   = {$urandom, $urandom};
            rst               = $urandom_range(0, 39) != 0;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
